// File: rtl/grn_attractor_detector_if.sv
// Control and result bus of the gene-network attractor detector.
// The initiator (master) starts runs and consumes results; the detector is the slave.
interface grn_attractor_detector_if #(
   parameter int NODES  = 8,
   parameter int STEP_W = 16
);
   logic              start;
   logic [NODES-1:0]  init_state;
   logic              busy;
   logic              res_valid;
   logic              res_ready;
   logic [STEP_W-1:0] res_meet_steps;
   logic [STEP_W-1:0] res_period;
   logic [NODES-1:0]  res_attractor;
   logic              res_timeout;

   modport master (
      output start,
      output init_state,
      output res_ready,
      input  busy,
      input  res_valid,
      input  res_meet_steps,
      input  res_period,
      input  res_attractor,
      input  res_timeout
   );

   modport slave (
      input  start,
      input  init_state,
      input  res_ready,
      output busy,
      output res_valid,
      output res_meet_steps,
      output res_period,
      output res_attractor,
      output res_timeout
   );
endinterface

// File: rtl/grn_attractor_detector.sv
// Step controller and Floyd cycle detector for a Boolean gene-network array.
// Nodes carry a tortoise (s0, half rate inside the node) and a hare (s1). The controller
// loads the nodes, steps both until s0==s1, then freezes the tortoise and steps the hare
// alone to measure the attractor period. One result per run leaves on a valid/ready port.
module grn_attractor_detector #(
   parameter int NODES     = 8,
   parameter int STEP_W    = 16,
   parameter int MAX_STEPS = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   grn_attractor_detector_if.slave bus,
   input  logic [NODES-1:0]        s0_vec,
   input  logic [NODES-1:0]        s1_vec,
   output logic                    reset_nos,
   output logic [NODES-1:0]        init_state_o,
   output logic                    start_s0,
   output logic                    start_s1
);

   localparam logic [STEP_W-1:0] MAX_C  = STEP_W'(MAX_STEPS);
   localparam logic [STEP_W-1:0] ZERO_C = {STEP_W{1'b0}};
   localparam logic [NODES-1:0]  NZERO  = {NODES{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_STEP   = 3'd3,
      ST_CMP    = 3'd4,
      ST_PSTEP  = 3'd5,
      ST_PCMP   = 3'd6,
      ST_DONE   = 3'd7
   } state_t;

   // Counters stop at the step limit instead of wrapping.
   function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
      logic [STEP_W-1:0] r;
      if (v >= MAX_C) begin
         r = MAX_C;
      end else begin
         r = v + STEP_W'(1);
      end
      return r;
   endfunction

   state_t            state_q,      state_d;
   logic [NODES-1:0]  init_q,       init_d;
   logic              reset_nos_q,  reset_nos_d;
   logic              start_s0_q,   start_s0_d;
   logic              start_s1_q,   start_s1_d;
   logic              busy_q,       busy_d;
   logic              res_valid_q,  res_valid_d;
   logic [STEP_W-1:0] step_q,       step_d;
   logic [STEP_W-1:0] period_q,     period_d;
   logic [STEP_W-1:0] meet_q,       meet_d;
   logic [NODES-1:0]  attractor_q,  attractor_d;
   logic              timeout_q,    timeout_d;

   // Next-state and next-output computation; strobes default low so they last one cycle.
   always_comb begin
      state_d     = state_q;
      init_d      = init_q;
      reset_nos_d = 1'b0;
      start_s0_d  = 1'b0;
      start_s1_d  = 1'b0;
      busy_d      = busy_q;
      res_valid_d = res_valid_q;
      step_d      = step_q;
      period_d    = period_q;
      meet_d      = meet_q;
      attractor_d = attractor_q;
      timeout_d   = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               init_d      = bus.init_state;
               busy_d      = 1'b1;
               reset_nos_d = 1'b1;   // high during LOAD
               state_d     = ST_LOAD;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            // Nodes now show init_state; start a fresh result.
            step_d      = ZERO_C;
            period_d    = ZERO_C;
            meet_d      = ZERO_C;
            attractor_d = NZERO;
            timeout_d   = 1'b0;
            start_s0_d  = 1'b1;      // high during STEP
            start_s1_d  = 1'b1;
            state_d     = ST_STEP;
         end
         ST_STEP: begin
            step_d  = sat_inc(step_q);
            state_d = ST_CMP;
         end
         ST_CMP: begin
            if (s0_vec == s1_vec) begin
               meet_d      = step_q;
               attractor_d = s1_vec;
               period_d    = ZERO_C;
               start_s1_d  = 1'b1;   // high during PSTEP, tortoise frozen
               state_d     = ST_PSTEP;
            end else if (step_q == MAX_C) begin
               meet_d      = step_q;
               timeout_d   = 1'b1;
               period_d    = ZERO_C;
               attractor_d = NZERO;
               res_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               start_s0_d  = 1'b1;
               start_s1_d  = 1'b1;
               state_d     = ST_STEP;
            end
         end
         ST_PSTEP: begin
            period_d = sat_inc(period_q);
            state_d  = ST_PCMP;
         end
         ST_PCMP: begin
            if (s1_vec == attractor_q) begin
               res_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else if (period_q == MAX_C) begin
               timeout_d   = 1'b1;
               period_d    = ZERO_C;
               attractor_d = NZERO;
               res_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               start_s1_d  = 1'b1;
               state_d     = ST_PSTEP;
            end
         end
         ST_DONE: begin
            // Result held until accepted; start pulses here are dropped.
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         init_q      <= NZERO;
         reset_nos_q <= 1'b0;
         start_s0_q  <= 1'b0;
         start_s1_q  <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         step_q      <= ZERO_C;
         period_q    <= ZERO_C;
         meet_q      <= ZERO_C;
         attractor_q <= NZERO;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         reset_nos_q <= reset_nos_d;
         start_s0_q  <= start_s0_d;
         start_s1_q  <= start_s1_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         step_q      <= step_d;
         period_q    <= period_d;
         meet_q      <= meet_d;
         attractor_q <= attractor_d;
         timeout_q   <= timeout_d;
      end
   end

   assign reset_nos          = reset_nos_q;
   assign init_state_o       = init_q;
   assign start_s0           = start_s0_q;
   assign start_s1           = start_s1_q;
   assign bus.busy           = busy_q;
   assign bus.res_valid      = res_valid_q;
   assign bus.res_meet_steps = meet_q;
   assign bus.res_period     = period_q;
   assign bus.res_attractor  = attractor_q;
   assign bus.res_timeout    = timeout_q;

endmodule

// File: tb/tb_grn_attractor_detector.sv
// Self-checking bench for grn_attractor_detector: behavioural node array driven by the
// detector's strobes, reference Floyd model feeding a scoreboard of expected results.
module tb_grn_attractor_detector;

   localparam int NODES  = 8;
   localparam int STEP_W = 16;
   localparam int MAXS   = 16;

   typedef struct {
      logic [15:0] meet;
      logic [15:0] period;
      logic [7:0]  attr;
      logic        to;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [NODES-1:0] s0_vec;
   logic [NODES-1:0] s1_vec;
   logic             ph;
   logic             reset_nos;
   logic [NODES-1:0] init_state_o;
   logic             start_s0;
   logic             start_s1;
   int               mode;
   int               total;
   int               bad;
   exp_t             sb_q[$];

   grn_attractor_detector_if #(.NODES(NODES), .STEP_W(STEP_W)) bus ();

   grn_attractor_detector #(.NODES(NODES), .STEP_W(STEP_W), .MAX_STEPS(MAXS)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .s0_vec       (s0_vec),
      .s1_vec       (s1_vec),
      .reset_nos    (reset_nos),
      .init_state_o (init_state_o),
      .start_s0     (start_s0),
      .start_s1     (start_s1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Network next-state functions selected by mode.
   function automatic logic [7:0] net_f(input int m, input logic [7:0] x);
      logic [7:0] r;
      case (m)
         0: r = x;                                            // identity
         1: r = (x == 8'h11) ? 8'h22 : (x == 8'h22) ? 8'h33 :
                (x == 8'h33) ? 8'h11 : x;                    // 3-ring
         2: r = (x < 8'd8) ? x + 8'd1 : 8'd5;                 // 0..4 transient, 5..8 ring
         3: r = x + 8'd1;                                     // 256-ring, never meets early
         default: r = x;
      endcase
      return r;
   endfunction

   // Behavioural nodes: hare steps on every strobe, tortoise on every second one.
   always @(posedge clk) begin
      if (reset_nos) begin
         s0_vec <= init_state_o;
         s1_vec <= init_state_o;
         ph     <= 1'b0;
      end else begin
         if (start_s1) s1_vec <= net_f(mode, s1_vec);
         if (start_s0) begin
            ph <= ~ph;
            if (ph) s0_vec <= net_f(mode, s0_vec);
         end
      end
   end

   // Reference detector result for a given network and initial state.
   function automatic exp_t model(input int m, input logic [7:0] init);
      exp_t       e;
      logic [7:0] h;
      logic [7:0] t;
      logic [7:0] y;
      bit         met;
      h = init; t = init; met = 1'b0;
      e.meet = 16'd0; e.period = 16'd0; e.attr = 8'd0; e.to = 1'b0;
      for (int k = 1; k <= MAXS && !met; k++) begin
         h = net_f(m, h);
         if (k % 2 == 0) t = net_f(m, t);
         if (h == t) begin
            met = 1'b1; e.meet = 16'(k); e.attr = h;
         end else if (k == MAXS) begin
            e.meet = 16'(MAXS); e.to = 1'b1;
         end
      end
      if (met) begin
         y = e.attr;
         for (int p = 1; p <= MAXS; p++) begin
            y = net_f(m, y);
            if (y == e.attr) begin
               e.period = 16'(p);
               break;
            end else if (p == MAXS) begin
               e.to = 1'b1; e.attr = 8'd0; e.period = 16'd0;
            end
         end
      end
      return e;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One run: push expectation, start, wait for result, optional back-pressure, accept.
   task automatic run(input int m, input logic [7:0] init, input int hold);
      exp_t e;
      exp_t x;
      int   waited;
      mode = m;
      e = model(m, init);
      sb_q.push_back(e);
      @(negedge clk);
      bus.init_state = init;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("busy_after_start", 32'(bus.busy), 32'd1);
      check_eq("init_state_o", 32'(init_state_o), 32'(init));
      waited = 0;
      while (!bus.res_valid && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check_eq("wait_res_valid", 32'(bus.res_valid), 32'd1);
      x = sb_q.pop_front();
      if (!bus.res_valid) return;
      for (int i = 0; i < hold; i++) begin
         bus.start = (i == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
         check_eq("hold_valid", 32'(bus.res_valid), 32'd1);
         check_eq("hold_busy", 32'(bus.busy), 32'd1);
         check_eq("hold_meet", 32'(bus.res_meet_steps), 32'(x.meet));
         check_eq("hold_attr", 32'(bus.res_attractor), 32'(x.attr));
      end
      bus.start = 1'b0;
      check_eq("meet_steps", 32'(bus.res_meet_steps), 32'(x.meet));
      check_eq("period", 32'(bus.res_period), 32'(x.period));
      check_eq("attractor", 32'(bus.res_attractor), 32'(x.attr));
      check_eq("timeout", 32'(bus.res_timeout), 32'(x.to));
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check_eq("valid_after_accept", 32'(bus.res_valid), 32'd0);
      check_eq("busy_after_accept", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check_eq("idle_stays_idle", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int waited;
      total = 0; bad = 0; mode = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.init_state = 8'h00; bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
      check_eq("rst_strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
      check_eq("rst_init_o", 32'(init_state_o), 32'd0);
      check_eq("rst_meet", 32'(bus.res_meet_steps), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      run(0, 8'hA5, 0);   // fixed point
      run(1, 8'h22, 0);   // 3-ring, start on cycle
      run(2, 8'h00, 0);   // transient 5, ring 4
      run(0, 8'h3C, 10);  // back-pressure with ignored start
      run(3, 8'h00, 0);   // timeout at the step limit

      // Asynchronous reset while stepping.
      mode = 2;
      @(negedge clk);
      bus.init_state = 8'h00; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 0;
      while (!(start_s0 && start_s1) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_eq("reach_step", 32'(start_s0 && start_s1), 32'd1);
      rst = 1'b0;
      #1;
      check_eq("midrst_strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
      check_eq("midrst_busy", 32'(bus.busy), 32'd0);
      check_eq("midrst_valid", 32'(bus.res_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run(2, 8'h00, 0);
      run(1, 8'h11, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
